// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb : parametrised 2R/1W register file with per-register busy      |
// |              scoreboard, optional write-through bypass and zero register. |
// | Revision   : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              flush,
    output logic              wb_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;
    logic              r_wb_err;
    logic              w_wr_zero;
    logic              w_rsv_zero;
    logic              w_wr_live;
    logic [ADDR_W-1:0] w_rd_addr [2];

    assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    assign w_wr_live  = wr_en && !w_wr_zero;

    // A same-cycle write-back to the reserved register frees it before the new set.
    assign rsv_ok = rsv_en && !flush && (!r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            logic              w_zero;
            logic              w_fwd;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_zero = (ZERO_REG != 0) && (w_rd_addr[p] == '0);
            assign w_fwd  = (BYPASS != 0) && wr_en && (wr_addr == w_rd_addr[p]);

            always_comb begin
                w_data = r_regs[w_rd_addr[p]];
                w_busy = r_busy[w_rd_addr[p]];
                if (w_fwd) begin
                    w_data = wr_data;
                    w_busy = 1'b0;
                end
                if (w_zero) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end
        end
    endgenerate

    assign rd_data_a = g_rd_port[0].w_data;
    assign rd_busy_a = g_rd_port[0].w_busy;
    assign rd_data_b = g_rd_port[1].w_data;
    assign rd_busy_b = g_rd_port[1].w_busy;
    assign wb_err    = r_wb_err;

    always_comb begin
        w_busy_next = r_busy;
        if (wr_en) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (rsv_ok && !w_rsv_zero) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_wr_live) begin
                r_regs[wr_addr] <= wr_data;
                if (!r_busy[wr_addr]) begin
                    r_wb_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
